// File: rtl/vga_timing_ctrl.sv
// Scan timing for the 640x480@60 colour-bar path: position counters, syncs,
// visible-area qualifier, frame-start pulse and the bar-rotation scheduler.
module vga_timing_ctrl #(
    parameter int HVID            = 640,
    parameter int HFP             = 16,
    parameter int HSYNC           = 96,
    parameter int HBP             = 48,
    parameter int VVID            = 480,
    parameter int VFP             = 10,
    parameter int VSYNC           = 2,
    parameter int VBP             = 33,
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic       clk_25,
    input  logic       rst_n,
    input  logic       enable,
    output logic [9:0] horizontal_num,
    output logic [9:0] vertical_num,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic [1:0] bar_shift
);

    localparam int HTOT = HVID + HFP + HSYNC + HBP;
    localparam int VTOT = VVID + VFP + VSYNC + VBP;

    localparam logic [9:0] H_LAST   = 10'(HTOT - 1);
    localparam logic [9:0] V_LAST   = 10'(VTOT - 1);
    localparam logic [9:0] H_VIS    = 10'(HVID);
    localparam logic [9:0] V_VIS    = 10'(VVID);
    localparam logic [9:0] HS_START = 10'(HVID + HFP);
    localparam logic [9:0] HS_END   = 10'(HVID + HFP + HSYNC);
    localparam logic [9:0] VS_START = 10'(VVID + VFP);
    localparam logic [9:0] VS_END   = 10'(VVID + VFP + VSYNC);
    localparam logic       ROTATE   = (FRAMES_PER_STEP != 0);
    localparam logic [7:0] FC_LAST  = ROTATE ? 8'(FRAMES_PER_STEP - 1) : 8'd0;

    // Scan position and frame scheduler state
    logic [9:0] h_reg, h_next;
    logic [9:0] v_reg, v_next;
    logic [7:0] fc_reg, fc_next;
    logic [1:0] bar_idx_reg, bar_idx_next;

    // Registered output stage
    logic [9:0] hpos_reg, hpos_next;
    logic [9:0] vpos_reg, vpos_next;
    logic       hsync_reg, hsync_next;
    logic       vsync_reg, vsync_next;
    logic       video_on_reg, video_on_next;
    logic       frame_start_reg, frame_start_next;
    logic [1:0] bar_shift_reg, bar_shift_next;

    logic line_end;
    logic frame_end;

    assign line_end  = (h_reg == H_LAST);
    assign frame_end = line_end && (v_reg == V_LAST);

    always_comb begin
        h_next = 10'd0;
        v_next = 10'd0;
        if (enable) begin
            if (line_end) begin
                h_next = 10'd0;
                v_next = frame_end ? 10'd0 : v_reg + 10'd1;
            end else begin
                h_next = h_reg + 10'd1;
                v_next = v_reg;
            end
        end
    end

    // fc counts only completed frames; a truncated frame never reaches frame_end
    always_comb begin
        fc_next      = fc_reg;
        bar_idx_next = bar_idx_reg;
        if (enable && frame_end && ROTATE) begin
            if (fc_reg == FC_LAST) begin
                fc_next      = 8'd0;
                bar_idx_next = bar_idx_reg + 2'd1;
            end else begin
                fc_next = fc_reg + 8'd1;
            end
        end
    end

    // Outputs describe the position held in h_reg/v_reg before this edge advances it
    always_comb begin
        hpos_next        = 10'd0;
        vpos_next        = 10'd0;
        hsync_next       = 1'b1;
        vsync_next       = 1'b1;
        video_on_next    = 1'b0;
        frame_start_next = 1'b0;
        bar_shift_next   = bar_shift_reg;
        if (enable) begin
            hpos_next        = h_reg;
            vpos_next        = v_reg;
            hsync_next       = !((h_reg >= HS_START) && (h_reg < HS_END));
            vsync_next       = !((v_reg >= VS_START) && (v_reg < VS_END));
            video_on_next    = (h_reg < H_VIS) && (v_reg < V_VIS);
            frame_start_next = (h_reg == 10'd0) && (v_reg == 10'd0);
            bar_shift_next   = bar_idx_reg;
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            h_reg           <= 10'd0;
            v_reg           <= 10'd0;
            fc_reg          <= 8'd0;
            bar_idx_reg     <= 2'd0;
            hpos_reg        <= 10'd0;
            vpos_reg        <= 10'd0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            video_on_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            bar_shift_reg   <= 2'd0;
        end else begin
            h_reg           <= h_next;
            v_reg           <= v_next;
            fc_reg          <= fc_next;
            bar_idx_reg     <= bar_idx_next;
            hpos_reg        <= hpos_next;
            vpos_reg        <= vpos_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            video_on_reg    <= video_on_next;
            frame_start_reg <= frame_start_next;
            bar_shift_reg   <= bar_shift_next;
        end
    end

    assign horizontal_num = hpos_reg;
    assign vertical_num   = vpos_reg;
    assign hsync          = hsync_reg;
    assign vsync          = vsync_reg;
    assign video_on       = video_on_reg;
    assign frame_start    = frame_start_reg;
    assign bar_shift      = bar_shift_reg;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-size instance for line timing, two shrunk
// instances (rotation every 2 frames / rotation off) for frame-level behaviour.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;

    always #5 clk = ~clk;

    logic [9:0] hn [3];
    logic [9:0] vn [3];
    logic       hs [3];
    logic       vs [3];
    logic       vo [3];
    logic       fs [3];
    logic [1:0] bs [3];

    vga_timing_ctrl #(.FRAMES_PER_STEP(60)) u_full (
        .clk_25(clk), .rst_n(rst_n), .enable(enable),
        .horizontal_num(hn[0]), .vertical_num(vn[0]), .hsync(hs[0]), .vsync(vs[0]),
        .video_on(vo[0]), .frame_start(fs[0]), .bar_shift(bs[0])
    );

    vga_timing_ctrl #(.HVID(8), .HFP(2), .HSYNC(3), .HBP(2), .VVID(4), .VFP(1), .VSYNC(2), .VBP(1),
                      .FRAMES_PER_STEP(2)) u_rot2 (
        .clk_25(clk), .rst_n(rst_n), .enable(enable),
        .horizontal_num(hn[1]), .vertical_num(vn[1]), .hsync(hs[1]), .vsync(vs[1]),
        .video_on(vo[1]), .frame_start(fs[1]), .bar_shift(bs[1])
    );

    vga_timing_ctrl #(.HVID(8), .HFP(2), .HSYNC(3), .HBP(2), .VVID(4), .VFP(1), .VSYNC(2), .VBP(1),
                      .FRAMES_PER_STEP(0)) u_rot0 (
        .clk_25(clk), .rst_n(rst_n), .enable(enable),
        .horizontal_num(hn[2]), .vertical_num(vn[2]), .hsync(hs[2]), .vsync(vs[2]),
        .video_on(vo[2]), .frame_start(fs[2]), .bar_shift(bs[2])
    );

    // Per-instance timing, matching the overrides above
    localparam int HV_A [3] = '{640, 8, 8};
    localparam int HF_A [3] = '{16, 2, 2};
    localparam int HS_A [3] = '{96, 3, 3};
    localparam int HT_A [3] = '{800, 15, 15};
    localparam int VV_A [3] = '{480, 4, 4};
    localparam int VF_A [3] = '{10, 1, 1};
    localparam int VS_A [3] = '{2, 2, 2};
    localparam int VT_A [3] = '{525, 8, 8};
    localparam int FP_A [3] = '{60, 2, 0};

    localparam logic [25:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};

    int errors = 0;
    int checks = 0;

    // Packed view: {h, v, hsync, vsync, video_on, frame_start, bar_shift}
    function automatic logic [25:0] dut_vec(input int i);
        return {hn[i], vn[i], hs[i], vs[i], vo[i], fs[i], bs[i]};
    endfunction

    // Expected outputs for the t-th position of a run, given f completed frames in total
    function automatic logic [25:0] model_out(input int i, input int t, input int f);
        int h, v, bar;
        logic hsy, vsy, von, fst;
        h   = t % HT_A[i];
        v   = (t / HT_A[i]) % VT_A[i];
        hsy = !((h >= HV_A[i] + HF_A[i]) && (h < HV_A[i] + HF_A[i] + HS_A[i]));
        vsy = !((v >= VV_A[i] + VF_A[i]) && (v < VV_A[i] + VF_A[i] + VS_A[i]));
        von = (h < HV_A[i]) && (v < VV_A[i]);
        fst = (h == 0) && (v == 0);
        bar = (FP_A[i] == 0) ? 0 : (f / FP_A[i]) % 4;
        return {10'(h), 10'(v), hsy, vsy, von, fst, 2'(bar)};
    endfunction

    int          m_t [3];
    int          m_f [3];
    logic [25:0] m_e [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_t[i] <= 0;
                m_f[i] <= 0;
                m_e[i] <= RESET_VEC;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (enable) begin
                    m_e[i] <= model_out(i, m_t[i], m_f[i]);
                    m_t[i] <= m_t[i] + 1;
                    if (m_t[i] % (HT_A[i] * VT_A[i]) == HT_A[i] * VT_A[i] - 1)
                        m_f[i] <= m_f[i] + 1;
                end else begin
                    m_t[i] <= 0;
                    m_e[i] <= {20'd0, 4'b1100, m_e[i][1:0]};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [25:0] got, input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock, then every instance compared against the model
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("model_u%0d", i), dut_vec(i), m_e[i]);
    endtask

    int d0_hs_low, d0_vo, d1_vs_low, d1_vo;
    logic [1:0] bar_seq [9];

    initial begin
        bar_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        d0_hs_low = 0; d0_vo = 0; d1_vs_low = 0; d1_vo = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        chk("reset_full", dut_vec(0), RESET_VEC);
        chk("reset_rot2", dut_vec(1), RESET_VEC);

        rst_n  = 1'b1;
        enable = 1'b1;
        for (int t = 0; t < 2450; t++) begin
            step();
            if (t < 800) begin
                d0_hs_low += (hs[0] == 1'b0) ? 1 : 0;
                d0_vo     += vo[0] ? 1 : 0;
            end
            if (t < 120) begin
                d1_vs_low += (vs[1] == 1'b0) ? 1 : 0;
                d1_vo     += vo[1] ? 1 : 0;
            end
            if (t % 120 == 0 && t / 120 < 9) begin
                chk($sformatf("rot2_bar_frame%0d", t / 120), {23'd0, fs[1], bs[1]}, {23'd0, 1'b1, bar_seq[t / 120]});
            end
            case (t)
                0:    chk("origin_full", dut_vec(0), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0});
                119:  chk("wrap_last_rot2", {hn[1], vn[1], 6'd0}, {10'd14, 10'd7, 6'd0});
                120:  chk("wrap_next_rot2", {hn[1], vn[1], vs[1], fs[1], 4'd0}, {10'd0, 10'd0, 1'b1, 1'b1, 4'd0});
                639:  chk("vo_639", {25'd0, vo[0]}, 26'd1);
                640:  chk("vo_640", {25'd0, vo[0]}, 26'd0);
                655:  chk("hs_655", {25'd0, hs[0]}, 26'd1);
                656:  chk("hs_656", {25'd0, hs[0]}, 26'd0);
                751:  chk("hs_751", {25'd0, hs[0]}, 26'd0);
                752:  chk("hs_752", {25'd0, hs[0]}, 26'd1);
                800:  chk("line1_full", {hn[0], vn[0], fs[0], 5'd0}, {10'd0, 10'd1, 1'b0, 5'd0});
                960:  chk("rot0_bar", {24'd0, bs[2]}, 26'd0);
                2400: chk("line3_full", {hn[0], vn[0], 6'd0}, {10'd0, 10'd3, 6'd0});
                default: ;
            endcase
        end
        chk("hs_low_per_line", 26'(d0_hs_low), 26'd96);
        chk("vo_per_line0", 26'(d0_vo), 26'd640);
        chk("vs_low_per_frame", 26'(d1_vs_low), 26'd30);
        chk("vo_per_frame", 26'(d1_vo), 26'd32);

        // Abort mid-frame: 20 frames done so far, rotation index 10 mod 4 = 2 must hold
        enable = 1'b0;
        step();
        chk("abort_rot2", dut_vec(1), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2});
        repeat (4) step();
        enable = 1'b1;
        step();
        chk("restart_rot2", {hn[1], vn[1], fs[1], 5'd0}, {10'd0, 10'd0, 1'b1, 5'd0});
        for (int t = 1; t <= 120; t++) step();
        // 21 completed frames -> index 2; counting the truncated frame would give 3
        chk("post_abort_bar", {23'd0, fs[1], bs[1]}, {23'd0, 1'b1, 2'd2});

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_full", dut_vec(0), RESET_VEC);
        chk("async_reset_rot2", dut_vec(1), RESET_VEC);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("origin_after_reset", dut_vec(1), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0});
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequencing controller for the 640x480@60 colour-bar display path.
- Generates the pixel position counters that drive the colour generator's horizontal input, plus hsync/vsync, the video-active qualifier and a frame-start pulse.
- Runs a frame scheduler that advances a 2-bit bar-rotation index every FRAMES_PER_STEP frames; the colour generator uses this index to rotate its four bars.

Parameters:
HVID, 640, visible pixels per line
HFP, 16, horizontal front porch (pixels)
HSYNC, 96, horizontal sync width (pixels)
HBP, 48, horizontal back porch (pixels)
VVID, 480, visible lines per frame
VFP, 10, vertical front porch (lines)
VSYNC, 2, vertical sync width (lines)
VBP, 33, vertical back porch (lines)
FRAMES_PER_STEP, 60, frames per bar_shift advance; 0 = rotation disabled; legal range 0..255

Ports:
clk_25  input  1  25 MHz pixel clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scan runs; 0 = scan held at origin, outputs idle
horizontal_num  output  10  pixel column of current output cycle
vertical_num  output  10  line of current output cycle
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
video_on  output  1  1 when position is inside the visible area
frame_start  output  1  one-cycle pulse at position (0,0)
bar_shift  output  2  bar-rotation index for the colour generator

Behaviour:
- Derived constants: HTOT = HVID+HFP+HSYNC+HBP (800); VTOT = VVID+VFP+VSYNC+VBP (525).
- Internal counters h (0..HTOT-1) and v (0..VTOT-1).
  - h increments every enabled cycle.
  - When h = HTOT-1, h wraps to 0 and v increments.
  - When h = HTOT-1 and v = VTOT-1, both wrap to 0 (frame wrap).
- Output stage is registered, with 1-cycle latency from the internal counters. All outputs are mutually aligned and describe the same position (h,v):
  - horizontal_num = h
  - vertical_num = v
  - hsync = 0 iff HVID+HFP <= h < HVID+HFP+HSYNC (656..751)
  - vsync = 0 iff VVID+VFP <= v < VVID+VFP+VSYNC (490..491)
  - video_on = (h < HVID) && (v < VVID)
  - frame_start = (h == 0) && (v == 0)
- Reset (rst_n = 0, asynchronous):
  - h = v = 0, frame counter = 0.
  - horizontal_num = 0, vertical_num = 0, hsync = 1, vsync = 1, video_on = 0, frame_start = 0, bar_shift = 0.
- Release of reset is synchronous to clk_25. The first edge with rst_n = 1 and enable = 1 produces outputs for position (0,0), with video_on = 1 and frame_start = 1.
- enable = 0:
  - At the next edge, h and v clear to 0 and the outputs take their reset values.
  - Frame counter and bar_shift hold.
- enable 0 -> 1: the scan restarts from (0,0) exactly as after reset. Deasserting enable mid-line or mid-frame truncates the frame without any partial-frame count.
- Frame scheduler (8-bit frame counter fc):
  - On each frame wrap with FRAMES_PER_STEP != 0:
    - If fc = FRAMES_PER_STEP-1: fc := 0 and bar_shift := bar_shift+1 (mod 4, so 3 -> 0).
    - Otherwise: fc := fc+1.
  - bar_shift changes on the same edge that presents frame_start, so a new value is valid for the whole frame starting at (0,0).
  - FRAMES_PER_STEP = 0: fc and bar_shift stay 0.
- Widths: all comparisons are unsigned at 10 bits; HTOT and VTOT must not exceed 1024.
- No state other than the above. No combinational path from enable to any output.

Test Plan:
- Reset and origin: assert rst_n=0 mid-frame (async, between edges) -> all outputs show reset values immediately. Release with enable=1 -> first edge gives h=0, v=0, video_on=1, frame_start=1.
- Horizontal timing: run 3 lines -> line period 800 cycles. hsync low exactly for horizontal_num 656..751 (96 cycles). video_on high for horizontal_num 0..639 on lines 0..479 only.
- Vertical and frame timing: run 2 full frames -> vsync low for vertical_num 490..491 (1600 cycles). frame_start pulses spaced 420000 cycles apart. video_on count per frame = 307200.
- Bar rotation with FRAMES_PER_STEP=2: run 9 frames -> bar_shift goes 0,0,1,1,2,2,3,3,0. Each change coincides with a frame_start cycle. With FRAMES_PER_STEP=0, bar_shift stays 0.
- Enable abort: drop enable at h=300, v=100 for 5 cycles -> next edge gives outputs at reset values with bar_shift unchanged. Re-enable -> scan restarts at (0,0) with frame_start=1; the truncated frame does not advance fc.
- Wrap boundary: observe h=799, v=524 -> next edge gives h=0, v=0, frame_start=1, and vsync already high (=1).
